// File: rtl/uart_rx_csr.sv
// uart_rx_csr: 8N1 UART receiver, RxFIFO and the read-to-clear image of ADDR_UART_RX.
// Optional feature: define UART_RX_FERR_EN for a sticky framing-error flag in bit 29.
module uart_rx_csr #(
   parameter int CLK_HZ     = 50_000_000,
   parameter int BAUD       = 115_200,
   parameter int FIFO_DEPTH = 4
) (
   input  logic        clk,
   input  logic        arst,
   input  logic        uart_rxd,
   input  logic        csr_rd,
   output logic [31:0] csr_rdata
);

   localparam int BIT_DIV = (CLK_HZ + BAUD / 2) / BAUD;
   localparam int DIV_W   = $clog2(BIT_DIV);
   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(BIT_DIV / 2 - 1);
   localparam logic [DIV_W-1:0] DIV_FULL = DIV_W'(BIT_DIV - 1);
   localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
   localparam logic [PTR_W:0]   PTR_ONE  = (PTR_W + 1)'(1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t           state;
   logic             rx_meta;
   logic             rxs;
   logic             rxs_prev;
   logic [1:0]       sync_fill;
   logic             fall;
   logic [DIV_W-1:0] div;
   logic [2:0]       bitcnt;
   logic [7:0]       shreg;
   logic             rx_push;
`ifdef UART_RX_FERR_EN
   logic             rx_ferr;
   logic             ferr;
`endif

   logic [7:0]       mem [FIFO_DEPTH];
   logic [PTR_W:0]   wr_ptr;
   logic [PTR_W:0]   rd_ptr;
   logic             empty;
   logic             full;
   logic             pop;
   logic             push_ok;
   logic             drop;

   logic             valid;
   logic             oflow;
   logic [7:0]       data;

   // sync_fill marks when rxs carries a real line sample, so a line held low
   // out of reset never looks like a 1->0 edge.
   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         rx_meta   <= 1'b1;
         rxs       <= 1'b1;
         sync_fill <= 2'b00;
         rxs_prev  <= 1'b0;
      end else begin
         rx_meta   <= uart_rxd;
         rxs       <= rx_meta;
         sync_fill <= {sync_fill[0], 1'b1};
         rxs_prev  <= rxs & sync_fill[1];
      end
   end

   assign fall = rxs_prev & ~rxs;

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state   <= IDLE;
         div     <= '0;
         bitcnt  <= '0;
         shreg   <= '0;
         rx_push <= 1'b0;
`ifdef UART_RX_FERR_EN
         rx_ferr <= 1'b0;
`endif
      end else begin
         rx_push <= 1'b0;
`ifdef UART_RX_FERR_EN
         rx_ferr <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (fall) begin
                  div   <= DIV_HALF;
                  state <= START;
               end
            end
            START: begin
               if (div == '0) begin
                  if (rxs) begin
                     state <= IDLE;
                  end else begin
                     div    <= DIV_FULL;
                     bitcnt <= '0;
                     state  <= DATA;
                  end
               end else begin
                  div <= div - DIV_ONE;
               end
            end
            DATA: begin
               if (div == '0) begin
                  shreg  <= {rxs, shreg[7:1]};
                  div    <= DIV_FULL;
                  bitcnt <= bitcnt + 3'd1;
                  if (bitcnt == 3'd7) state <= STOP;
               end else begin
                  div <= div - DIV_ONE;
               end
            end
            STOP: begin
               if (div == '0) begin
                  rx_push <= rxs;
`ifdef UART_RX_FERR_EN
                  rx_ferr <= ~rxs;
`endif
                  state   <= IDLE;
               end else begin
                  div <= div - DIV_ONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // A push into a full FIFO is still accepted when the head leaves on the same edge.
   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
   assign pop     = ~valid & ~empty;
   assign push_ok = rx_push & (~full | pop);
   assign drop    = rx_push & full & ~pop;

   // NOTE: FIFO storage has no reset; the pointers alone say which entries are live.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr[PTR_W-1:0]] <= shreg;
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         valid <= 1'b0;
         oflow <= 1'b0;
         data  <= '0;
      end else begin
         if (csr_rd && valid) begin
            valid <= 1'b0;
         end else if (pop) begin
            valid <= 1'b1;
            data  <= mem[rd_ptr[PTR_W-1:0]];
         end
         if (drop)        oflow <= 1'b1;
         else if (csr_rd) oflow <= 1'b0;
      end
   end

`ifdef UART_RX_FERR_EN
   always_ff @(posedge clk or posedge arst) begin
      if (arst)         ferr <= 1'b0;
      else if (rx_ferr) ferr <= 1'b1;
      else if (csr_rd)  ferr <= 1'b0;
   end

   assign csr_rdata = {valid, oflow, ferr, 21'd0, data};
`else
   assign csr_rdata = {valid, oflow, 22'd0, data};
`endif

endmodule
